// File: rtl/wb_port_arbiter.sv
// Arbiter for the shared register-file write port: in-order writeback wins, late
// long-latency results wait in a small FIFO and steal a slot when they starve.
module wb_port_arbiter #(
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                       clk_i,
    input  logic                       reset_i,
    input  logic                       wb_valid_i,
    input  logic                       wb_reg_write_i,
    input  logic [4:0]                 wb_rd_i,
    input  logic [31:0]                wb_result_i,
    input  logic                       lu_valid_i,
    output logic                       lu_ready_o,
    input  logic [4:0]                 lu_rd_i,
    input  logic [31:0]                lu_data_i,
    output logic                       rf_we_o,
    output logic [4:0]                 rf_rd_o,
    output logic [31:0]                rf_wd_o,
    output logic                       stall_w_o,
    output logic [$clog2(DEPTH):0]     lu_pending_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned GW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] COUNT_FULL = CW'(DEPTH);
    localparam logic [GW-1:0] AGE_MAX    = GW'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_WB,
        GNT_LU,
        GNT_STEAL
    } grant_e;

    logic [4:0]    mem_rd_q [DEPTH];
    logic [31:0]   mem_wd_q [DEPTH];
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [GW-1:0] age_q, age_d;

    grant_e grant;
    logic   wb_req, head_valid, steal, push, pop;

    assign wb_req     = wb_valid_i & wb_reg_write_i & (wb_rd_i != 5'd0);
    assign head_valid = (count_q != '0);
    assign steal      = head_valid & (age_q == AGE_MAX) & wb_req;

    // Ready looks at registered occupancy only, so a same-cycle pop never
    // opens a slot in a full FIFO and there is no lu_valid_i -> lu_ready_o path.
    assign lu_ready_o   = (count_q < COUNT_FULL);
    assign push         = lu_valid_i & lu_ready_o & (lu_rd_i != 5'd0);
    assign lu_pending_o = count_q;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // through the case leaves a signal unassigned (no latch inference).
        grant     = GNT_NONE;
        rf_we_o   = 1'b0;
        rf_rd_o   = wb_rd_i;
        rf_wd_o   = wb_result_i;
        stall_w_o = 1'b0;
        pop       = 1'b0;

        if (!reset_i)        grant = GNT_NONE;
        else if (steal)      grant = GNT_STEAL;
        else if (wb_req)     grant = GNT_WB;
        else if (head_valid) grant = GNT_LU;

        case (grant)
            GNT_STEAL: begin
                rf_we_o   = 1'b1;
                rf_rd_o   = mem_rd_q[rd_ptr_q];
                rf_wd_o   = mem_wd_q[rd_ptr_q];
                stall_w_o = 1'b1;
                pop       = 1'b1;
            end
            GNT_WB: begin
                rf_we_o = 1'b1;
            end
            GNT_LU: begin
                rf_we_o = 1'b1;
                rf_rd_o = mem_rd_q[rd_ptr_q];
                rf_wd_o = mem_wd_q[rd_ptr_q];
                pop     = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        age_d    = age_q;

        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A pop hands the port to a fresh head, which starts waiting from zero.
        if (pop || !head_valid) age_d = '0;
        else if (age_q != AGE_MAX) age_d = age_q + GW'(1);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            age_q    <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            age_q    <= age_d;
        end
    end

    // NOTE: the storage array has no reset; count_q alone decides which
    // entries are meaningful, so stale contents are never observed.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_rd_q[wr_ptr_q] <= lu_rd_i;
            mem_wd_q[wr_ptr_q] <= lu_data_i;
        end
    end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus random traffic,
// all compared against a queue-based reference model of the arbitration rules.
module tb_wb_port_arbiter;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 4;

    logic        clk_i = 1'b0;
    logic        reset_i;
    logic        wb_valid, wb_reg_write;
    logic [4:0]  wb_rd;
    logic [31:0] wb_result;
    logic        lu_valid;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        lu_ready_o, rf_we_o, stall_w_o;
    logic [4:0]  rf_rd_o;
    logic [31:0] rf_wd_o;
    logic [$clog2(DEPTH):0] lu_pending_o;

    wb_port_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk_i          (clk_i),
        .reset_i        (reset_i),
        .wb_valid_i     (wb_valid),
        .wb_reg_write_i (wb_reg_write),
        .wb_rd_i        (wb_rd),
        .wb_result_i    (wb_result),
        .lu_valid_i     (lu_valid),
        .lu_ready_o     (lu_ready_o),
        .lu_rd_i        (lu_rd),
        .lu_data_i      (lu_data),
        .rf_we_o        (rf_we_o),
        .rf_rd_o        (rf_rd_o),
        .rf_wd_o        (rf_wd_o),
        .stall_w_o      (stall_w_o),
        .lu_pending_o   (lu_pending_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } entry_t;

    entry_t mq[$];
    int     m_age;
    logic   m_handshake;
    logic   prev_stall;
    logic   obs_stall;
    logic   obs_we;
    logic [4:0] obs_rd;
    int     checks   = 0;
    int     failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: compare at the falling edge, then advance the model on the rising edge.
    task automatic step();
        logic   req, has, stl, pop, push, ready;
        entry_t head;
        @(negedge clk_i);
        req   = wb_valid && wb_reg_write && (wb_rd != 5'd0);
        has   = (mq.size() != 0);
        ready = (mq.size() < DEPTH);
        stl   = has && (m_age == STARVE_LIMIT) && req;
        pop   = stl || (!req && has);
        head  = has ? mq[0] : '0;
        check("lu_ready", {31'd0, lu_ready_o}, {31'd0, ready});
        check("pending", 32'(lu_pending_o), 32'(mq.size()));
        check("rf_we", {31'd0, rf_we_o}, {31'd0, req || has});
        check("stall", {31'd0, stall_w_o}, {31'd0, stl});
        if (req || has) begin
            check("rf_rd", 32'(rf_rd_o), pop ? 32'(head.rd) : 32'(wb_rd));
            check("rf_wd", rf_wd_o, pop ? head.data : wb_result);
        end
        check("no_b2b_steal", {31'd0, prev_stall & stall_w_o}, 32'd0);
        prev_stall = stall_w_o;
        obs_stall  = stall_w_o;
        obs_we     = rf_we_o;
        obs_rd     = rf_rd_o;
        @(posedge clk_i);
        m_handshake = lu_valid && ready;
        push        = m_handshake && (lu_rd != 5'd0);
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back('{rd: lu_rd, data: lu_data});
        if (pop || !has) m_age = 0;
        else if (m_age < STARVE_LIMIT) m_age++;
        #1;
    endtask

    task automatic set_wb(input logic v, input logic w, input logic [4:0] rd, input logic [31:0] res);
        wb_valid = v; wb_reg_write = w; wb_rd = rd; wb_result = res;
    endtask

    logic       t2_stall [6];
    logic [4:0] t2_rd    [6];
    int         acc;
    logic       seen_full;
    int         we_after_reset;

    initial begin
        reset_i = 1'b0;
        set_wb(1'b1, 1'b1, 5'd3, 32'h3333);
        lu_valid = 1'b0; lu_rd = '0; lu_data = '0;
        m_age = 0; prev_stall = 1'b0;
        #2;
        // Reset values, with a live writeback request that must still be gated.
        check("rst_we", {31'd0, rf_we_o}, 32'd0);
        check("rst_stall", {31'd0, stall_w_o}, 32'd0);
        check("rst_ready", {31'd0, lu_ready_o}, 32'd1);
        check("rst_pending", 32'(lu_pending_o), 32'd0);
        repeat (2) @(posedge clk_i);
        @(negedge clk_i);
        reset_i = 1'b1;
        set_wb(1'b0, 1'b0, 5'd0, 32'd0);
        @(posedge clk_i); #1;

        // Idle pipeline, single push reaches the port next cycle.
        lu_valid = 1'b1; lu_rd = 5'd5; lu_data = 32'hDEADBEEF;
        step();
        lu_valid = 1'b0;
        check("t1_pending_after_push", 32'(lu_pending_o), 32'd1);
        step();
        check("t1_we", {31'd0, obs_we}, 32'd1);
        check("t1_rd", 32'(obs_rd), 32'd5);
        check("t1_pending_after_pop", 32'(lu_pending_o), 32'd0);

        // Starvation: head waits STARVE_LIMIT cycles, then steals one slot.
        set_wb(1'b1, 1'b1, 5'd3, 32'h0000_0333);
        lu_valid = 1'b1; lu_rd = 5'd7; lu_data = 32'h0000_0777;
        step();
        lu_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            t2_stall[k] = obs_stall;
            t2_rd[k]    = obs_rd;
        end
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t2_stall_c%0d", k + 1), {31'd0, t2_stall[k]}, (k == 4) ? 32'd1 : 32'd0);
            check($sformatf("t2_rd_c%0d", k + 1), 32'(t2_rd[k]), (k == 4) ? 32'd7 : 32'd3);
        end

        // Fill the FIFO under continuous writeback; a third offer is held off.
        acc = 0; seen_full = 1'b0;
        lu_valid = 1'b1;
        for (int k = 0; k < 40 && acc < 3; k++) begin
            lu_rd = 5'(9 + acc); lu_data = 32'(32'hA0 + acc);
            if (!lu_ready_o) seen_full = 1'b1;
            step();
            if (m_handshake) acc++;
        end
        lu_valid = 1'b0;
        check("t3_accepted", 32'(acc), 32'd3);
        check("t3_seen_full", {31'd0, seen_full}, 32'd1);
        set_wb(1'b1, 1'b0, 5'd3, 32'd0);
        repeat (4) step();

        // rd=0 push completes the handshake but is dropped.
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'h1234;
        step();
        check("t4_handshake", {31'd0, m_handshake}, 32'd1);
        lu_valid = 1'b0;
        check("t4_pending", 32'(lu_pending_o), 32'd0);
        repeat (3) step();

        // Pairs queued behind writeback, then drained back-to-back; pointers wrap.
        for (int p = 0; p < 6; p++) begin
            set_wb(1'b1, 1'b1, 5'd4, 32'h44);
            for (int e = 0; e < 2; e++) begin
                lu_valid = 1'b1; lu_rd = 5'(1 + 2 * p + e); lu_data = 32'(32'hB00 + 2 * p + e);
                step();
            end
            lu_valid = 1'b0;
            set_wb(1'b1, 1'b0, 5'd4, 32'h44);
            step();
            check($sformatf("t5_first_p%0d", p), 32'(obs_rd), 32'(1 + 2 * p));
            step();
            check($sformatf("t5_second_p%0d", p), 32'(obs_rd), 32'(2 + 2 * p));
        end

        // Random traffic against the model.
        for (int k = 0; k < 600; k++) begin
            set_wb(1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                   $urandom);
            if ($urandom_range(0, 3) == 0) set_wb(1'b1, 1'b1, 5'($urandom_range(1, 31)), $urandom);
            lu_valid = 1'($urandom);
            lu_rd    = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            lu_data  = $urandom;
            step();
        end
        lu_valid = 1'b0;
        set_wb(1'b0, 1'b0, 5'd0, 32'd0);
        repeat (3) step();

        // Reset mid-operation with two entries queued and age at 3.
        set_wb(1'b1, 1'b1, 5'd6, 32'h66);
        acc = 0;
        for (int k = 0; k < 20 && !(mq.size() == 2 && m_age == 3); k++) begin
            lu_valid = (mq.size() < 2); lu_rd = 5'(20 + acc); lu_data = 32'(32'hC0 + acc);
            step();
            if (m_handshake) acc++;
        end
        lu_valid = 1'b0;
        check("t6_setup_pending", 32'(lu_pending_o), 32'd2);
        check("t6_setup_age", 32'(m_age), 32'd3);
        #2;
        reset_i = 1'b0;
        #1;
        check("t6_rst_we", {31'd0, rf_we_o}, 32'd0);
        check("t6_rst_stall", {31'd0, stall_w_o}, 32'd0);
        check("t6_rst_ready", {31'd0, lu_ready_o}, 32'd1);
        check("t6_rst_pending", 32'(lu_pending_o), 32'd0);
        mq.delete(); m_age = 0; prev_stall = 1'b0;
        @(negedge clk_i);
        reset_i = 1'b1;
        set_wb(1'b0, 1'b0, 5'd0, 32'd0);
        @(posedge clk_i); #1;
        we_after_reset = 0;
        for (int k = 0; k < 8; k++) begin
            step();
            if (obs_we) we_after_reset++;
        end
        check("t6_no_write_after_reset", 32'(we_after_reset), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/wb_port_arbiter.md
# wb_port_arbiter

Arbiter for the single register-file write port, shared between in-order writeback and a long-latency unit (divider, load-return path) that completes out of band. In-order writeback has priority. Late results queue in a small FIFO and use the port in idle writeback slots. A starvation guard stalls writeback for one cycle to force a queued write through. The block sits between the writeback stage, the long-latency unit and the register file, and drives the writeback stall request into the hazard unit.

## Interface
- DEPTH, 2: late-result FIFO entries (power of two, ≥2).
- STARVE_LIMIT, 4: cycles a FIFO head may wait before a forced steal (≥1).

- clk_i  in  1  clock, all state updates on rising edge.
- reset_i  in  1  reset, asynchronous, active-low.
- wb_valid_i  in  1  writeback stage holds a valid instruction.
- wb_reg_write_i  in  1  that instruction writes a register.
- wb_rd_i  in  5  writeback destination register.
- wb_result_i  in  32  writeback result data.
- lu_valid_i  in  1  long-latency unit offers a result.
- lu_ready_o  out  1  FIFO can accept; a push happens when lu_valid_i & lu_ready_o.
- lu_rd_i  in  5  late-result destination.
- lu_data_i  in  32  late-result data.
- rf_we_o  out  1  register-file write enable.
- rf_rd_o  out  5  register-file write address.
- rf_wd_o  out  32  register-file write data.
- stall_w_o  out  1  freeze request for the writeback register (ORed into stall_w by the hazard unit).
- lu_pending_o  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- wb_req = wb_valid_i & wb_reg_write_i & (wb_rd_i != 0).
- FIFO: circular buffer with read and write pointers plus a count. Pointers wrap at DEPTH.
- lu_ready_o = (count < DEPTH). It is derived from state only, so a pop in the same cycle does not open a slot when the FIFO is full.
- A push with lu_rd_i == 0 completes the handshake but is discarded: nothing is enqueued and count is unchanged.
- Age counter: $clog2(STARVE_LIMIT+1) bits. It is 0 when the FIFO is empty. It increments each cycle the head is valid and not popped, saturating at STARVE_LIMIT. It clears to 0 on every pop, so a new head starts at 0.
- steal = (count != 0) & (age == STARVE_LIMIT) & wb_req.
- Grant, in priority order, evaluated combinationally each cycle:
  - steal: FIFO head drives the port, pop, stall_w_o=1. The pipeline write is deferred because the writeback register holds and the same write is presented next cycle.
  - wb_req: pipeline drives the port, no pop, stall_w_o=0.
  - count != 0: FIFO head drives the port, pop, stall_w_o=0.
  - otherwise: rf_we_o=0.
- A steal never occurs on two consecutive cycles, because the age counter is cleared by the pop. Worst-case throughput loss to writeback is therefore one cycle per STARVE_LIMIT+1 cycles.
- Simultaneous push and pop when the FIFO is not full: count unchanged, both pointers advance. If the FIFO is empty, a pushed entry is not visible until the next cycle (no bypass).
- WAW ordering between the two sources is guaranteed by the upstream scoreboard. The block does no rd comparison.
- rf_rd_o and rf_wd_o are don't-care when rf_we_o=0. The bench masks them.

## Timing
- Reset asserted: count=0, pointers=0, age=0, lu_ready_o=1, stall_w_o=0, rf_we_o=0 (gated by reset), lu_pending_o=0.
- Reset mid-operation: queued entries are lost immediately and outputs take reset values asynchronously.
- Push-to-write latency: minimum 1 cycle (push at edge N, write in cycle N+1 if writeback is idle). Maximum STARVE_LIMIT+1 cycles after the entry reaches the head.
- rf_*, stall_w_o: combinational from state and wb_* inputs. No input-to-lu_ready_o path.
- Register file samples the write on the rising edge ending the grant cycle.

## Test plan
- Idle pipeline, push rd=5 data=0xDEADBEEF at edge 0 -> cycle 1 rf_we_o=1, rf_rd_o=5, rf_wd_o=0xDEADBEEF, stall_w_o=0, lu_pending_o 1->0.
- Continuous wb_req (rd=3), one push rd=7 with STARVE_LIMIT=4 -> pipeline owns the port for 4 cycles, 5th cycle stall_w_o=1 and write rd=7, next cycle pipeline rd=3 written again.
- Fill FIFO (2 pushes) under continuous wb_req -> lu_ready_o=0. A third lu_valid_i is held off. Ready returns the cycle after the first pop. No steal on back-to-back cycles.
- Push rd=0 with data=0x1234 -> handshake completes, lu_pending_o stays 0, rf_we_o never asserts for it.
- Two queued entries with wb_reg_write_i=0 -> writes on consecutive cycles in push order, with pointer wrap exercised over 5+ push/pop pairs.
- Assert reset_i low with 2 entries queued and age=3 -> outputs take reset values without a clock edge, and no queued write occurs after release.
